// File: rtl/fifo1_pkg.sv
// Shared defaults and helpers for the fifo1 single-clock FWFT FIFO.
package fifo1_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic int depth(input int asize);
    return 1 << asize;
  endfunction
endpackage

// File: rtl/fifo1_mem.sv
// Storage array for fifo1: one synchronous write port and one combinational read port.
module fifo1_mem
  import fifo1_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);
  localparam int DEPTH = depth(ASIZE);

  // Contents are deliberately not reset; flags gate the visibility of stale words.
  logic [DSIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo1.sv
// Single-clock first-word-fall-through FIFO, DSIZE wide, 2^ASIZE deep.
// Define FIFO1_COUNT_EN to expose the occupancy output 'count'.
module fifo1
  import fifo1_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
`ifdef FIFO1_COUNT_EN
  ,
  output logic [ASIZE:0]   count
`endif
);
  logic [ASIZE:0] r_wptr, r_rptr;
  logic           r_wfull, r_rempty;
  logic [ASIZE:0] w_wptr_nxt, w_rptr_nxt;
  logic           w_push, w_pop;
  logic           w_full_nxt, w_empty_nxt;

  assign w_push = winc & ~r_wfull;
  assign w_pop  = rinc & ~r_rempty;

  assign w_wptr_nxt = r_wptr + {{ASIZE{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{ASIZE{1'b0}}, w_pop};

  // Full when pointers match in address but differ in the wrap bit.
  assign w_empty_nxt = (w_rptr_nxt == w_wptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt == {~w_rptr_nxt[ASIZE], w_rptr_nxt[ASIZE-1:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
      r_wfull  <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_rempty <= w_empty_nxt;
      r_wfull  <= w_full_nxt;
    end
  end

  fifo1_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (rdata)
  );

  assign wfull  = r_wfull;
  assign rempty = r_rempty;

`ifdef FIFO1_COUNT_EN
  assign count = r_wptr - r_rptr;
`endif
endmodule

// File: tb/tb_fifo1.sv
// Self-checking bench for fifo1: directed vector table, corner sequences, random traffic vs a queue model.
module tb_fifo1;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DSIZE-1:0] wdata;
  logic             winc, rinc;
  logic             wfull, rempty;
  logic [DSIZE-1:0] rdata;
`ifdef FIFO1_COUNT_EN
  logic [ASIZE:0]   count;
`endif

  fifo1 #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
`ifdef FIFO1_COUNT_EN
    ,
    .count  (count)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [DSIZE-1:0] q[$];

  typedef struct {
    logic             w;
    logic [DSIZE-1:0] d;
    logic             r;
    logic             e_empty;
    logic             e_full;
    logic [DSIZE-1:0] e_data;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a FIFO is a bounded queue; pushes refused when full, pops refused when empty.
  task automatic cyc(input logic w, input logic [DSIZE-1:0] d, input logic r);
    int sz;
    sz = q.size();
    winc = w; wdata = d; rinc = r;
    @(posedge clk);
    if (r && sz > 0) void'(q.pop_front());
    if (w && sz < DEPTH) q.push_back(d);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".rempty"}, 32'(rempty), 32'(q.size() == 0));
    chk({nm, ".wfull"},  32'(wfull),  32'(q.size() == DEPTH));
    if (q.size() > 0) chk({nm, ".rdata"}, 32'(rdata), 32'(q[0]));
`ifdef FIFO1_COUNT_EN
    chk({nm, ".count"}, 32'(count), 32'(q.size()));
`endif
  endtask

  initial begin
    winc = 1'b0; rinc = 1'b0; wdata = '0; rst_n = 1'b0;

    // Reset held 5 cycles with winc asserted: nothing may be written.
    winc = 1'b1; wdata = 8'hEE;
    repeat (5) @(negedge clk);
    chk("rst.rempty", 32'(rempty), 32'd1);
    chk("rst.wfull",  32'(wfull),  32'd0);
`ifdef FIFO1_COUNT_EN
    chk("rst.count", 32'(count), 32'd0);
`endif
    winc = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.after_release_empty", 32'(rempty), 32'd1);

    // Directed vector table, expectations written out by hand.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C}; // push+pop on empty: push only
    tbl[4]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}; // underflow ignored
    tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d.rempty", i), 32'(rempty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.wfull", i),  32'(wfull),  32'(tbl[i].e_full));
      if (!tbl[i].e_empty) chk($sformatf("tbl%0d.rdata", i), 32'(rdata), 32'(tbl[i].e_data));
    end

    // Fill to full; 17th push dropped.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk_model($sformatf("fill%0d", i));
    end
    chk("fill.wfull_at16", 32'(wfull), 32'd1);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("fill.drop_wfull", 32'(wfull), 32'd1);
    chk("fill.drop_head",  32'(rdata), 32'h00);

    // Push+pop at full: only the pop happens, wfull drops, then 0x55 refills it.
    cyc(1'b1, 8'h77, 1'b1);
    chk("full_pp.wfull", 32'(wfull), 32'd0);
    chk("full_pp.head",  32'(rdata), 32'h01);
    cyc(1'b1, 8'h55, 1'b0);
    chk("full_pp.refull", 32'(wfull), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d.rdata", i), 32'(rdata), (i == DEPTH - 1) ? 32'h55 : 32'(i + 1));
      cyc(1'b0, 8'h00, 1'b1);
      chk_model($sformatf("drain%0d", i));
    end
    chk("drain.rempty", 32'(rempty), 32'd1);

    // Alternating push/pop with random data; wraps the pointers several times.
    for (int it = 0; it < 2; it++) begin
      for (int c = 0; c < 32; c++) begin
        cyc(c[0] == 1'b0, 8'($urandom), c[0] == 1'b1);
        chk_model($sformatf("alt%0d_%0d", it, c));
      end
    end

    // Random traffic with biased push/pop rates to sweep fill levels.
    for (int c = 0; c < 300; c++) begin
      int bias;
      bias = (c < 100) ? 70 : (c < 200) ? 30 : 50;
      cyc($urandom_range(99) < bias, 8'($urandom), $urandom_range(99) >= bias);
      chk_model($sformatf("rnd%0d", c));
    end

    // Async reset mid-stream with 5 entries: empty without any clock edge.
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    chk_model("pre_arst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.rempty", 32'(rempty), 32'd1);
    chk("arst.wfull",  32'(wfull),  32'd0);
`ifdef FIFO1_COUNT_EN
    chk("arst.count", 32'(count), 32'd0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 8'h9D, 1'b0);
    chk_model("post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
